// File: rtl/bitstream_integrator_array.sv
// bitstream_integrator_array
// Counts CHANNELS parallel bitstreams over one shared observation window and
// presents every channel's total at once with a single-cycle valid strobe.
// The window is either capture-gated or a fixed number of cycles; counting is
// unipolar (x=1 -> +1) or bipolar (x=1 -> +1, x=0 -> -1). Accumulators never
// wrap: they stick at their limit and raise a per-channel saturation flag.
module bitstream_integrator_array #(
    parameter int CHANNELS = 4,
    parameter int COUNT_W  = 16,
    parameter int WIN_W    = 16
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic [CHANNELS-1:0]           x,
    input  logic                          capture,
    input  logic                          mode_window,
    input  logic                          bipolar,
    input  logic [WIN_W-1:0]              window_len,
    output logic [CHANNELS*COUNT_W-1:0]   y,
    output logic                          y_valid,
    output logic [CHANNELS-1:0]           sat,
    output logic                          busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READING = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    // Accumulator limits and unit step
    localparam logic [COUNT_W-1:0] UMAX    = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] SMAX    = {1'b0, {(COUNT_W-1){1'b1}}};
    localparam logic [COUNT_W-1:0] SMIN    = {1'b1, {(COUNT_W-1){1'b0}}};
    localparam logic [COUNT_W-1:0] ONE     = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIN_W-1:0]   WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

    // One saturating accumulation step. Result is {hit_limit, next_value};
    // a step that would cross a limit holds the limit instead.
    function automatic logic [COUNT_W:0] sat_step(
        input logic [COUNT_W-1:0] acc,
        input logic               bit_in,
        input logic               bip
    );
        logic [COUNT_W:0] r;
        r = {1'b0, acc};
        if (bip) begin
            if (bit_in) begin
                if (acc == SMAX) r = {1'b1, acc};
                else             r = {1'b0, acc + ONE};
            end else begin
                if (acc == SMIN) r = {1'b1, acc};
                else             r = {1'b0, acc - ONE};
            end
        end else begin
            if (bit_in) begin
                if (acc == UMAX) r = {1'b1, acc};
                else             r = {1'b0, acc + ONE};
            end else begin
                r = {1'b0, acc};
            end
        end
        return r;
    endfunction

    state_t                                state_q, state_d;
    logic [CHANNELS-1:0][COUNT_W-1:0]      acc_q, acc_d;
    logic [CHANNELS-1:0]                   sat_acc_q, sat_acc_d;
    logic [WIN_W-1:0]                      win_cnt_q, win_cnt_d;
    logic                                  cfg_window_q, cfg_window_d;
    logic                                  cfg_bipolar_q, cfg_bipolar_d;
    logic [CHANNELS*COUNT_W-1:0]           y_q, y_d;
    logic [CHANNELS-1:0]                   sat_q, sat_d;
    logic                                  y_valid_q, y_valid_d;
    logic [CHANNELS-1:0][COUNT_W:0]        step_s;
    logic                                  accumulate_s;

    // Candidate next value and limit-hit flag for every channel this cycle
    always_comb begin
        step_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            step_s[i] = sat_step(acc_q[i], x[i], cfg_bipolar_q);
        end
    end

    // Next-state, window control and result capture
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        sat_acc_d     = sat_acc_q;
        win_cnt_d     = win_cnt_q;
        cfg_window_d  = cfg_window_q;
        cfg_bipolar_d = cfg_bipolar_q;
        y_d           = y_q;
        sat_d         = sat_q;
        y_valid_d     = 1'b0;
        accumulate_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Start cycle only clears and latches config; it never counts
                acc_d     = '0;
                sat_acc_d = '0;
                if (capture) begin
                    cfg_window_d  = mode_window;
                    cfg_bipolar_d = bipolar;
                    win_cnt_d     = window_len;
                    if (mode_window && (window_len == '0)) begin
                        state_d = ST_OUTPUT;
                    end else begin
                        state_d = ST_READING;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READING: begin
                if (cfg_window_q) begin
                    // Fixed window: capture ignored, count down each cycle
                    accumulate_s = 1'b1;
                    win_cnt_d    = win_cnt_q - WIN_ONE;
                    if (win_cnt_q == WIN_ONE) begin
                        state_d = ST_OUTPUT;
                    end else begin
                        state_d = ST_READING;
                    end
                end else begin
                    if (capture) begin
                        accumulate_s = 1'b1;
                        state_d      = ST_READING;
                    end else begin
                        state_d = ST_OUTPUT;
                    end
                end
            end
            ST_OUTPUT: begin
                y_d       = acc_q;
                sat_d     = sat_acc_q;
                y_valid_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accumulate_s) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_d[i]     = step_s[i][COUNT_W-1:0];
                sat_acc_d[i] = sat_acc_q[i] | step_s[i][COUNT_W];
            end
        end else begin
            accumulate_s = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q       <= ST_IDLE;
            acc_q         <= '0;
            sat_acc_q     <= '0;
            win_cnt_q     <= '0;
            cfg_window_q  <= 1'b0;
            cfg_bipolar_q <= 1'b0;
            y_q           <= '0;
            sat_q         <= '0;
            y_valid_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            sat_acc_q     <= sat_acc_d;
            win_cnt_q     <= win_cnt_d;
            cfg_window_q  <= cfg_window_d;
            cfg_bipolar_q <= cfg_bipolar_d;
            y_q           <= y_d;
            sat_q         <= sat_d;
            y_valid_q     <= y_valid_d;
        end
    end

    assign y       = y_q;
    assign sat     = sat_q;
    assign y_valid = y_valid_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bitstream_integrator_array.sv
// Directed bench for bitstream_integrator_array (CHANNELS=4, COUNT_W=8, WIN_W=8).
// Inputs are driven on the falling edge and outputs sampled on the falling edge.
module tb_bitstream_integrator_array;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [3:0]  x;
    logic        capture;
    logic        mode_window;
    logic        bipolar;
    logic [7:0]  window_len;
    logic [31:0] y;
    logic        y_valid;
    logic [3:0]  sat;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    bitstream_integrator_array #(
        .CHANNELS (4),
        .COUNT_W  (8),
        .WIN_W    (8)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .x           (x),
        .capture     (capture),
        .mode_window (mode_window),
        .bipolar     (bipolar),
        .window_len  (window_len),
        .y           (y),
        .y_valid     (y_valid),
        .sat         (sat),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic             bip;
        logic [7:0]       len;
        logic [7:0][3:0]  xs;
        logic [31:0]      exp_y;
        logic [3:0]       exp_sat;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Fixed-window run; garbage on config inputs and toggled capture during READING
    task automatic win_run(input string name, input logic bip, input logic [7:0] len,
                           input logic [7:0][3:0] xs, input logic [31:0] exp_y,
                           input logic [3:0] exp_sat);
        int lat;
        int pulses;
        @(negedge clk);
        capture = 1'b1; mode_window = 1'b1; bipolar = bip; window_len = len; x = 4'hF;
        @(posedge clk);
        lat = -1; pulses = 0;
        for (int c = 1; c <= int'(len) + 4; c++) begin
            @(negedge clk);
            if (y_valid) begin
                pulses++;
                if (lat < 0) lat = c;
            end
            if (c <= int'(len)) x = xs[c-1];
            else                x = 4'h0;
            capture     = (c < int'(len)) ? c[0] : 1'b0;
            mode_window = ~bip;
            bipolar     = ~bip;
            window_len  = 8'hAA;
        end
        chk({name, ".latency"}, 32'(lat), 32'(int'(len) + 2));
        chk({name, ".pulses"}, 32'(pulses), 32'd1);
        chk({name, ".y"}, y, exp_y);
        chk({name, ".sat"}, {28'd0, sat}, {28'd0, exp_sat});
    endtask

    // Capture-gated run of n accumulate cycles with constant x
    task automatic gated_run(input string name, input logic bip, input int n,
                             input logic [3:0] xv, input logic [31:0] exp_y,
                             input logic [3:0] exp_sat);
        int lat;
        int pulses;
        logic busy_run;
        logic busy_after;
        @(negedge clk);
        capture = 1'b1; mode_window = 1'b0; bipolar = bip; window_len = 8'd0; x = xv;
        @(posedge clk);
        busy_run = 1'b0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == 1) busy_run = busy;
            bipolar = ~bip;
            mode_window = 1'b1;
        end
        @(negedge clk);
        capture = 1'b0;
        lat = -1; pulses = 0; busy_after = 1'b1;
        for (int d = 1; d <= 5; d++) begin
            @(negedge clk);
            if (y_valid) begin
                pulses++;
                if (lat < 0) lat = d;
            end
            if (d == 3) busy_after = busy;
        end
        chk({name, ".busy_run"}, {31'd0, busy_run}, 32'd1);
        chk({name, ".latency"}, 32'(lat), 32'd2);
        chk({name, ".pulses"}, 32'(pulses), 32'd1);
        chk({name, ".y"}, y, exp_y);
        chk({name, ".sat"}, {28'd0, sat}, {28'd0, exp_sat});
        chk({name, ".busy_after"}, {31'd0, busy_after}, 32'd0);
    endtask

    // Time limit: every wait above is bounded, this is a last-resort guard
    initial begin
        #500000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        int nv;
        logic busy_seen;

        vt[0] = '{"win_uni5", 1'b0, 8'd5, 32'hFFFFFFFF, 32'h05050505, 4'h0};
        vt[1] = '{"win_bip6", 1'b1, 8'd6,
                  {4'h0, 4'h0, 4'h1, 4'h5, 4'h9, 4'hD, 4'h9, 4'hD}, 32'h0200FA06, 4'h0};
        vt[2] = '{"win_uni3", 1'b0, 8'd3,
                  {4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h7, 4'h3, 4'h1}, 32'h00010203, 4'h0};
        vt[3] = '{"win_bip4_zero", 1'b1, 8'd4, 32'h00000000, 32'hFCFCFCFC, 4'h0};
        vt[4] = '{"win_len0", 1'b0, 8'd0, 32'hFFFFFFFF, 32'h00000000, 4'h0};
        vt[5] = '{"win_bip2", 1'b1, 8'd2,
                  {4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hA, 4'hA}, 32'h02FE02FE, 4'h0};

        n_rst = 1'b0; x = 4'h0; capture = 1'b0; mode_window = 1'b0;
        bipolar = 1'b0; window_len = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.y", y, 32'h0);
        chk("reset.y_valid", {31'd0, y_valid}, 32'd0);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.sat", {28'd0, sat}, 32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        // Gated unipolar: 10 accumulate cycles of 0101
        gated_run("gated_uni10", 1'b0, 10, 4'b0101, 32'h000A000A, 4'h0);

        // Fixed-window vectors
        for (int k = 0; k < 6; k++) begin
            win_run(vt[k].name, vt[k].bip, vt[k].len, vt[k].xs, vt[k].exp_y, vt[k].exp_sat);
        end

        // Saturation, then recovery on a clean window
        gated_run("sat_uni300", 1'b0, 300, 4'hF, 32'hFFFFFFFF, 4'hF);
        gated_run("sat_bip200", 1'b1, 200, 4'h0, 32'h80808080, 4'hF);
        win_run("after_sat", 1'b0, 8'd3, 32'hFFFFFFFF, 32'h03030303, 4'h0);

        // Reset in the middle of a long window
        @(negedge clk);
        capture = 1'b1; mode_window = 1'b1; bipolar = 1'b0; window_len = 8'd100; x = 4'hF;
        @(posedge clk);
        for (int c = 1; c < 50; c++) begin
            @(negedge clk);
            capture = 1'b0;
        end
        @(negedge clk);
        n_rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst.busy", {31'd0, busy}, 32'd0);
        chk("midrst.y", y, 32'h0);
        chk("midrst.y_valid", {31'd0, y_valid}, 32'd0);
        n_rst = 1'b1;
        pulses = 0; busy_seen = 1'b0;
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            if (y_valid) pulses++;
            if (busy) busy_seen = 1'b1;
        end
        chk("midrst.no_strobe", 32'(pulses), 32'd0);
        chk("midrst.no_busy", {31'd0, busy_seen}, 32'd0);
        win_run("post_rst4", 1'b0, 8'd4, 32'hFFFFFFFF, 32'h04040404, 4'h0);

        // Back-to-back: capture held high through OUTPUT into IDLE
        @(negedge clk);
        capture = 1'b1; mode_window = 1'b1; bipolar = 1'b0; window_len = 8'd2; x = 4'hF;
        @(posedge clk);
        nv = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (y_valid) begin
                nv++;
                if (nv == 1) begin
                    chk("b2b.first_cycle", 32'(c), 32'd4);
                    chk("b2b.first_y", y, 32'h02020202);
                end else begin
                    chk("b2b.second_cycle", 32'(c), 32'd9);
                    chk("b2b.second_y", y, 32'hFDFDFDFD);
                end
            end
            if (c == 4) begin
                bipolar = 1'b1; window_len = 8'd3; x = 4'h0; capture = 1'b1;
            end else if (c >= 5) begin
                capture = 1'b0;
            end else begin
                capture = 1'b1;
            end
        end
        chk("b2b.strobes", 32'(nv), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
